// File: rtl/div_clk_monitor.sv
// div_clk_monitor: health check for a divided clock that is generated as a register on clk.
// Measures the period and high time of div_in in clk cycles, declares lock after LOCK_CNT
// consecutive in-spec periods, and reports loss of lock.
//
// Ports:
//   clk         single clock; div_in is a register on this clock
//   rst         synchronous, active-high reset
//   en          monitor enable; 0 forces IDLE and clears the counters
//   div_in      divided clock under test
//   clr_err     clears err_sticky (a same-cycle set wins)
//   period_vld  1-cycle pulse: new measurement on period_out/high_out
//   period_out  last measured period, in clk cycles
//   high_out    last measured high time, in clk cycles
//   locked      1 while in LOCKED
//   err         1-cycle pulse on loss of lock
//   err_sticky  set by err, cleared by clr_err
module div_clk_monitor #(
  parameter int unsigned EXP_PERIOD = 3,
  parameter int unsigned EXP_HIGH   = 1,
  parameter int unsigned LOCK_CNT   = 4,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             div_in,
  input  logic             clr_err,
  output logic             period_vld,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out,
  output logic             locked,
  output logic             err,
  output logic             err_sticky
);

  localparam int unsigned GoodW = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] ExpPer     = CNT_W'(EXP_PERIOD);
  localparam logic [CNT_W-1:0] ExpHigh    = CNT_W'(EXP_HIGH);
  localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(2 * EXP_PERIOD);

  typedef enum logic [2:0] {StIdle, StWait, StAcq, StLocked, StFault} state_e;

  state_e           state_q, state_d;
  logic             d_q;
  logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
  logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
  logic [GoodW-1:0] good_cnt_q, good_cnt_d;
  logic [CNT_W-1:0] period_q, high_q;
  logic             vld_q;
  logic             sticky_q, sticky_d;
  logic             rise, good, timeout, meas;

  assign rise    = div_in & ~d_q;
  // good/timeout look at the counts accumulated up to (not including) this cycle
  assign good    = (per_cnt_q == ExpPer) && (hi_cnt_q == ExpHigh);
  assign timeout = ~rise && (per_cnt_q == TimeoutVal);

  // Period/high counters; a rise restarts both at 1 since the rise cycle is itself high.
  always_comb begin
    per_cnt_d = per_cnt_q;
    hi_cnt_d  = hi_cnt_q;
    if (!en) begin
      per_cnt_d = '0;
      hi_cnt_d  = '0;
    end else if (rise) begin
      per_cnt_d = CNT_W'(1);
      hi_cnt_d  = CNT_W'(1);
    end else begin
      if (per_cnt_q != '1) per_cnt_d = per_cnt_q + CNT_W'(1);
      if (div_in && (hi_cnt_q != '1)) hi_cnt_d = hi_cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    meas       = 1'b0;
    if (!en) begin
      state_d    = StIdle;
      good_cnt_d = '0;
    end else begin
      unique case (state_q)
        StIdle: state_d = StWait;
        StWait: begin
          // first rise only arms the measurement
          if (rise) begin
            state_d    = StAcq;
            good_cnt_d = '0;
          end
        end
        StAcq: begin
          if (rise) begin
            meas = 1'b1;
            if (good) begin
              good_cnt_d = good_cnt_q + GoodW'(1);
              if (good_cnt_d == GoodW'(LOCK_CNT)) state_d = StLocked;
            end else begin
              good_cnt_d = '0;
            end
          end else if (timeout) begin
            state_d    = StWait;
            good_cnt_d = '0;
          end
        end
        StLocked: begin
          meas = rise;
          if ((rise && !good) || timeout) state_d = StFault;
        end
        StFault: begin
          state_d    = StWait;
          good_cnt_d = '0;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    sticky_d = sticky_q;
    if (state_q == StFault) begin
      sticky_d = 1'b1;
    end else if (clr_err) begin
      sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      d_q        <= 1'b0;
      per_cnt_q  <= '0;
      hi_cnt_q   <= '0;
      good_cnt_q <= '0;
      period_q   <= '0;
      high_q     <= '0;
      vld_q      <= 1'b0;
      sticky_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      d_q        <= div_in;
      per_cnt_q  <= per_cnt_d;
      hi_cnt_q   <= hi_cnt_d;
      good_cnt_q <= good_cnt_d;
      vld_q      <= meas;
      sticky_q   <= sticky_d;
      if (meas) begin
        period_q <= per_cnt_q;
        high_q   <= hi_cnt_q;
      end
    end
  end

  assign period_vld = vld_q;
  assign period_out = period_q;
  assign high_out   = high_q;
  assign locked     = (state_q == StLocked);
  assign err        = (state_q == StFault);
  assign err_sticky = sticky_q;

endmodule

// File: tb/tb_div_clk_monitor.sv
// Self-checking bench for div_clk_monitor. The reference model keeps the raw div_in history
// since the last rising edge in a queue and derives period/high time from its length and
// number of ones; the lock/fault behaviour is tracked as a simple mode variable.
module tb_div_clk_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       div_in = 1'b0;
  logic       clr_err = 1'b0;
  logic       period_vld;
  logic [7:0] period_out;
  logic [7:0] high_out;
  logic       locked;
  logic       err;
  logic       err_sticky;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  div_clk_monitor dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .div_in    (div_in),
    .clr_err   (clr_err),
    .period_vld(period_vld),
    .period_out(period_out),
    .high_out  (high_out),
    .locked    (locked),
    .err       (err),
    .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  logic [19:0] dut_vec;
  assign dut_vec = {period_vld, period_out, high_out, locked, err, err_sticky};

  // Reference model
  localparam int MIdle = 0, MWait = 1, MAcq = 2, MLocked = 3, MFault = 4;
  int         m_mode = MIdle;
  bit         m_prev = 1'b0;
  bit         m_hist[$];
  int         m_good = 0;
  bit         m_sticky = 1'b0;
  bit         m_vld = 1'b0;
  logic [7:0] m_per_o = '0;
  logic [7:0] m_hi_o = '0;
  logic [19:0] m_vec = '0;

  // Drive one cycle of inputs, advance past the edge, and update the model to match.
  task automatic step(input bit r, input bit e, input bit d, input bit c);
    bit rise, good_r, tmo;
    int per, hi, old;
    rst = r; en = e; div_in = d; clr_err = c;
    @(posedge clk);
    #1;
    cyc++;
    if (r) begin
      m_mode = MIdle; m_prev = 0; m_hist.delete(); m_good = 0;
      m_sticky = 0; m_vld = 0; m_per_o = '0; m_hi_o = '0;
    end else begin
      rise = d && !m_prev;
      m_prev = d;
      old = m_mode;
      m_vld = 0;
      if (!e) begin
        m_mode = MIdle; m_hist.delete(); m_good = 0;
      end else begin
        per = m_hist.size();
        hi = 0;
        foreach (m_hist[i]) hi += int'(m_hist[i]);
        if (per > 255) per = 255;
        if (hi > 255) hi = 255;
        good_r = rise && per == 3 && hi == 1;
        tmo = !rise && per == 6;
        if (rise && (m_mode == MAcq || m_mode == MLocked)) begin
          m_vld = 1; m_per_o = 8'(per); m_hi_o = 8'(hi);
        end
        case (m_mode)
          MIdle: m_mode = MWait;
          MWait: if (rise) begin m_mode = MAcq; m_good = 0; end
          MAcq: begin
            if (rise) begin
              if (good_r) begin
                m_good++;
                if (m_good == 4) m_mode = MLocked;
              end else m_good = 0;
            end else if (tmo) begin
              m_mode = MWait; m_good = 0;
            end
          end
          MLocked: if ((rise && !good_r) || tmo) m_mode = MFault;
          default: begin m_mode = MWait; m_good = 0; end
        endcase
        if (rise) m_hist.delete();
        m_hist.push_back(d);
      end
      if (old == MFault) m_sticky = 1;
      else if (c) m_sticky = 0;
    end
    m_vec = {m_vld, m_per_o, m_hi_o, m_mode == MLocked, m_mode == MFault, m_sticky};
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0);
    step(1, 0, 1, 1);
    total++;
    if (dut_vec !== 20'd0) begin
      bad++; $display("FAIL reset_outputs got=%h exp=%h", dut_vec, 20'd0);
    end
  endtask

  task automatic test_lock();
    bit first = 1'b1;
    int rises = 0;
    step(0, 1, 0, 0);
    for (int p = 0; p < 5; p++) begin
      for (int k = 0; k < 3; k++) begin
        step(0, 1, k == 2, 0);
        total++;
        if (dut_vec !== m_vec) begin
          bad++; $display("FAIL lock_vec cyc=%0d got=%h exp=%h", cyc, dut_vec, m_vec);
        end
        if (period_vld && first) begin
          first = 0;
          total++;
          if ({period_out, high_out} !== {8'd3, 8'd1}) begin
            bad++; $display("FAIL first_meas got=%0d/%0d exp=3/1", period_out, high_out);
          end
        end
      end
      rises++;
      if (rises == 4) begin
        total++;
        if (locked !== 1'b0) begin
          bad++; $display("FAIL early_lock got=%b exp=0", locked);
        end
      end
    end
    total++;
    if (locked !== 1'b1) begin
      bad++; $display("FAIL lock_after_5 got=%b exp=1", locked);
    end
  endtask

  task automatic test_glitch();
    bit [3:0] g = 4'b0001;
    int errs = 0;
    for (int k = 3; k >= 0; k--) begin
      step(0, 1, g[k], 0);
      errs += int'(err);
      total++;
      if (dut_vec !== m_vec) begin
        bad++; $display("FAIL glitch_vec cyc=%0d got=%h exp=%h", cyc, dut_vec, m_vec);
      end
    end
    for (int p = 0; p < 5; p++) begin
      for (int k = 0; k < 3; k++) begin
        step(0, 1, k == 2, 0);
        errs += int'(err);
        if (p == 0 && k == 0) begin
          total++;
          if ({locked, err_sticky} !== 2'b01) begin
            bad++; $display("FAIL post_fault got=%b%b exp=01", locked, err_sticky);
          end
        end
        total++;
        if (dut_vec !== m_vec) begin
          bad++; $display("FAIL relock_vec cyc=%0d got=%h exp=%h", cyc, dut_vec, m_vec);
        end
      end
    end
    total++;
    if (errs !== 1) begin
      bad++; $display("FAIL err_pulses got=%0d exp=1", errs);
    end
    total++;
    if (locked !== 1'b1) begin
      bad++; $display("FAIL relock got=%b exp=1", locked);
    end
  endtask

  task automatic test_timeout();
    int err_step = -1;
    for (int i = 1; i <= 10; i++) begin
      step(0, 1, 0, 0);
      if (err && err_step < 0) err_step = i;
      total++;
      if (dut_vec !== m_vec) begin
        bad++; $display("FAIL timeout_vec cyc=%0d got=%h exp=%h", cyc, dut_vec, m_vec);
      end
    end
    total++;
    if (err_step !== 6) begin
      bad++; $display("FAIL timeout_step got=%0d exp=6", err_step);
    end
    total++;
    if ({locked, err, err_sticky} !== 3'b001) begin
      bad++; $display("FAIL timeout_end got=%b%b%b exp=001", locked, err, err_sticky);
    end
  endtask

  task automatic test_clr();
    bit [3:0] g = 4'b0001;
    for (int p = 0; p < 5; p++) begin
      for (int k = 0; k < 3; k++) begin
        step(0, 1, k == 2, 0);
        total++;
        if (dut_vec !== m_vec) begin
          bad++; $display("FAIL clr_lock_vec cyc=%0d got=%h exp=%h", cyc, dut_vec, m_vec);
        end
      end
    end
    for (int k = 3; k >= 0; k--) step(0, 1, g[k], 0);
    total++;
    if (err !== 1'b1) begin
      bad++; $display("FAIL clr_err_pulse got=%b exp=1", err);
    end
    step(0, 1, 0, 1);
    total++;
    if (err_sticky !== 1'b1) begin
      bad++; $display("FAIL clr_same_cycle got=%b exp=1", err_sticky);
    end
    step(0, 1, 0, 0);
    step(0, 1, 0, 1);
    total++;
    if (err_sticky !== 1'b0) begin
      bad++; $display("FAIL clr_alone got=%b exp=0", err_sticky);
    end
  endtask

  task automatic test_high2();
    int vlds = 0;
    for (int p = 0; p < 8; p++) begin
      for (int k = 0; k < 3; k++) begin
        step(0, 1, k != 0, 0);
        if (period_vld) begin
          vlds++;
          total++;
          if ({period_out, high_out} !== {8'd3, 8'd2}) begin
            bad++; $display("FAIL high2_meas got=%0d/%0d exp=3/2", period_out, high_out);
          end
        end
        total++;
        if ({locked, err} !== 2'b00) begin
          bad++; $display("FAIL high2_flags cyc=%0d got=%b%b exp=00", cyc, locked, err);
        end
      end
    end
    total++;
    if (vlds !== 7) begin
      bad++; $display("FAIL high2_count got=%0d exp=7", vlds);
    end
  endtask

  task automatic test_en_drop();
    for (int p = 0; p < 2; p++)
      for (int k = 0; k < 3; k++) step(0, 1, k == 2, 0);
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < 3; k++) begin
        step(0, 0, k == 2, 0);
        total++;
        if ({period_vld, locked, period_out} !== {2'b00, 8'd3}) begin
          bad++; $display("FAIL en_drop got=%b%b/%0d exp=00/3", period_vld, locked, period_out);
        end
      end
    end
    for (int p = 0; p < 6; p++) begin
      for (int k = 0; k < 3; k++) begin
        step(0, 1, k == 2, 0);
        total++;
        if (dut_vec !== m_vec) begin
          bad++; $display("FAIL en_relock_vec cyc=%0d got=%h exp=%h", cyc, dut_vec, m_vec);
        end
      end
    end
    total++;
    if (locked !== 1'b1) begin
      bad++; $display("FAIL en_relock got=%b exp=1", locked);
    end
    step(1, 1, 0, 0);
    total++;
    if (dut_vec !== 20'd0) begin
      bad++; $display("FAIL rst_locked got=%h exp=%h", dut_vec, 20'd0);
    end
    step(0, 1, 0, 0);
  endtask

  task automatic test_random();
    int len, hi;
    while (cyc < 900) begin
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : 3;
      hi = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, len)) : 1;
      for (int k = 0; k < len; k++) begin
        step($urandom_range(0, 199) == 0, $urandom_range(0, 49) != 0, k >= len - hi,
             $urandom_range(0, 19) == 0);
        total++;
        if (dut_vec !== m_vec) begin
          bad++; $display("FAIL random_vec cyc=%0d got=%h exp=%h", cyc, dut_vec, m_vec);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_glitch();
    test_timeout();
    test_clr();
    test_high2();
    test_en_drop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

endmodule
